parking_gate_controller: RTL
============================

Name: parking_gate_controller

Overview:
- Sequences the single shared barrier gate of the parking lane and grants it to entry or exit requests.
- Sits downstream of the sensor state machine, consuming its one-cycle enters/exits pulses, and owns the authoritative occupancy count.
- Enforces the capacity limit.
- Arbitrates entry and exit requests round-robin.
- Drives the gate motor with timed raise/hold/lower phases and an obstruction reversal.

Parameters:
- CAPACITY, 8, maximum cars in the lot; entry is denied when count == CAPACITY.
- CNT_W, 32, width of count.
- MOVE_CYCLES, 50, clock cycles for a full raise or full lower motion.
- OPEN_TIMEOUT, 500, cycles the gate stays open waiting for a pass event.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_in  in  1  entry button, one-cycle pulse.
- req_out  in  1  exit button, one-cycle pulse.
- enters  in  1  one-cycle pulse from the sensor FSM: a car completed entry.
- exits  in  1  one-cycle pulse from the sensor FSM: a car completed exit.
- lane_busy  in  1  level; sensor1 | sensor2, meaning an object is under the gate.
- motor_up  out  1  drive gate upward.
- motor_down  out  1  drive gate downward.
- gate_open  out  1  gate fully open (state OPEN).
- dir_out  out  1  direction of the current grant: 0 = entry, 1 = exit.
- deny_in  out  1  one-cycle pulse: entry request rejected because the lot is full.
- deny_out  out  1  one-cycle pulse: exit request rejected because the lot is empty.
- full  out  1  count == CAPACITY.
- count  out  CNT_W  cars currently in the lot.

Behaviour:
- Reset values (synchronous): state IDLE; all outputs 0; count 0; pend_in 0; pend_out 0; last_served 1, so entry wins the first tie; timer 0.
- Request latching: req_in sets pend_in, req_out sets pend_out. Pending flags are held until the request is granted or denied. A repeated request while pending has no effect.
- Count update: on every cycle, in any state:
  - enters alone: +1, saturating at CAPACITY.
  - exits alone: -1, saturating at 0.
  - enters and exits together: no change.
  - full is combinational from count.
- State IDLE:
  - Candidates: pend_in, pend_out.
  - If both are pending, grant the side opposite last_served.
  - An entry grant with count == CAPACITY is not granted: clear pend_in, pulse deny_in, stay IDLE. Same for exit with count == 0, using deny_out. A valid grant on the other side is still evaluated in the same cycle.
  - On a valid grant: set dir_out, clear that pend flag, update last_served, load timer = MOVE_CYCLES, go to RAISE.
- State RAISE: motor_up = 1. Timer decrements each cycle; at timer == 1, go to OPEN with timer = OPEN_TIMEOUT.
- State OPEN: gate_open = 1. Exit conditions:
  - Pass event: enters when dir_out = 0, or exits when dir_out = 1. Sets a pass-done flag.
  - Pass-done with lane_busy = 0, or timeout (timer reaches 1) with lane_busy = 0: go to LOWER with timer = MOVE_CYCLES.
  - If lane_busy = 1, remain in OPEN; the timer holds at 1.
  - A pass event in the wrong direction updates count only.
- State LOWER: motor_down = 1.
  - If lane_busy rises, go to RAISE with timer = MOVE_CYCLES (obstruction reversal). The grant is kept; pass-done is kept.
  - At timer == 1, go to IDLE.
- Pending requests during a busy period: requests arriving outside IDLE stay pending. Full/empty is evaluated at grant time, not at request time.
- motor_up and motor_down are never both 1. Both are registered outputs.
- Reset asserted in any state returns to IDLE next edge with all outputs cleared, including an open gate.

Test Plan:
- Reset, req_in, then enters pulse 10 cycles after gate_open -> RAISE for 50 cycles, OPEN, LOWER for 50 cycles, IDLE; count = 1; motor_up and motor_down never overlap.
- req_in and req_out in the same cycle with count = 3 -> entry served first (dir_out = 0); exit served in the next IDLE (dir_out = 1). With one enters and one exits pass, count ends at 3.
- Drive count to CAPACITY = 8, then req_in -> deny_in pulses one cycle, no motor activity, count stays 8. Then req_out and exits -> count 7, and the next req_in is granted.
- req_out at count = 0 -> deny_out pulses; enters and exits in the same cycle leave count unchanged.
- Grant entry with no pass event -> OPEN lasts 500 cycles, then LOWER; count unchanged. Repeat with lane_busy held high at timeout -> stays OPEN until lane_busy drops, then LOWER.
- During LOWER cycle 20, assert lane_busy -> next state RAISE, full 50 cycles; then pass event and clear lane -> LOWER completes. Assert reset mid-RAISE -> next edge IDLE, outputs 0, count 0.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Barrier gate sequencer for a single parking lane: round-robin entry/exit grants,
// capacity enforcement, occupancy count and timed raise/open/lower with obstruction reversal.
module parking_gate_controller #(
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MOVE_CYCLES  = 50,
    parameter int unsigned OPEN_TIMEOUT = 500
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             enters,
    input  logic             exits,
    input  logic             lane_busy,
    output logic             motor_up,
    output logic             motor_down,
    output logic             gate_open,
    output logic             dir_out,
    output logic             deny_in,
    output logic             deny_out,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned TMax = (OPEN_TIMEOUT > MOVE_CYCLES) ? OPEN_TIMEOUT : MOVE_CYCLES;
    localparam int unsigned TW   = $clog2(TMax + 1);

    typedef enum logic [1:0] {StIdle, StRaise, StOpen, StLower} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_in_q, pend_in_d;
    logic             pend_out_q, pend_out_d;
    logic             last_q, last_d;
    logic             dir_q, dir_d;
    logic             pass_done_q, pass_done_d;
    logic             deny_in_q, deny_in_d;
    logic             deny_out_q, deny_out_d;
    logic             motor_up_q, motor_up_d;
    logic             motor_down_q, motor_down_d;
    logic             gate_open_q, gate_open_d;

    logic is_full, is_empty, pass, ok_in, ok_out, grant_out;

    assign is_full  = (count_q == CNT_W'(CAPACITY));
    assign is_empty = (count_q == '0);
    assign pass     = dir_q ? exits : enters;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            count_q      <= '0;
            pend_in_q    <= 1'b0;
            pend_out_q   <= 1'b0;
            last_q       <= 1'b1;
            dir_q        <= 1'b0;
            pass_done_q  <= 1'b0;
            deny_in_q    <= 1'b0;
            deny_out_q   <= 1'b0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            gate_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            pend_in_q    <= pend_in_d;
            pend_out_q   <= pend_out_d;
            last_q       <= last_d;
            dir_q        <= dir_d;
            pass_done_q  <= pass_done_d;
            deny_in_q    <= deny_in_d;
            deny_out_q   <= deny_out_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            gate_open_q  <= gate_open_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        count_d     = count_q;
        pend_in_d   = pend_in_q | req_in;
        pend_out_d  = pend_out_q | req_out;
        last_d      = last_q;
        dir_d       = dir_q;
        pass_done_d = pass_done_q;
        deny_in_d   = 1'b0;
        deny_out_d  = 1'b0;
        ok_in       = 1'b0;
        ok_out      = 1'b0;
        grant_out   = 1'b0;

        if (enters && !exits && !is_full) begin
            count_d = count_q + CNT_W'(1);
        end else if (exits && !enters && !is_empty) begin
            count_d = count_q - CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                ok_in  = pend_in_q && !is_full;
                ok_out = pend_out_q && !is_empty;
                if (pend_in_q && is_full) begin
                    pend_in_d = 1'b0;
                    deny_in_d = 1'b1;
                end
                if (pend_out_q && is_empty) begin
                    pend_out_d = 1'b0;
                    deny_out_d = 1'b1;
                end
                if (ok_in || ok_out) begin
                    // last_q = 1 means exit was served last, so entry wins a tie.
                    grant_out   = ok_out && (!ok_in || !last_q);
                    dir_d       = grant_out;
                    last_d      = grant_out;
                    if (grant_out) pend_out_d = 1'b0;
                    else           pend_in_d  = 1'b0;
                    pass_done_d = 1'b0;
                    timer_d     = TW'(MOVE_CYCLES);
                    state_d     = StRaise;
                end
            end
            StRaise: begin
                if (timer_q == TW'(1)) begin
                    timer_d = TW'(OPEN_TIMEOUT);
                    state_d = StOpen;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StOpen: begin
                if (pass) pass_done_d = 1'b1;
                if (!lane_busy && (pass_done_q || pass || timer_q == TW'(1))) begin
                    timer_d = TW'(MOVE_CYCLES);
                    state_d = StLower;
                end else if (timer_q > TW'(1)) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StLower: begin
                if (lane_busy) begin
                    timer_d = TW'(MOVE_CYCLES);
                    state_d = StRaise;
                end else if (timer_q == TW'(1)) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Motor and gate outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        motor_up_d   = (state_d == StRaise);
        motor_down_d = (state_d == StLower);
        gate_open_d  = (state_d == StOpen);
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign gate_open  = gate_open_q;
    assign dir_out    = dir_q;
    assign deny_in    = deny_in_q;
    assign deny_out   = deny_out_q;
    assign full       = is_full;
    assign count      = count_q;

endmodule
